// File: rtl/fm_demodulate.sv
// Quadrature FM discriminator: d[n] = I[n-1]*Q[n] - Q[n-1]*I[n], summed over
// 2^DECIM_LOG2 values and dumped as the top OUTPUT_WIDTH bits of the sum.
module fm_demodulate #(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 16,
  parameter int DECIM_LOG2   = 3
) (
  input  logic                           clk_in,
  input  logic                           RST,
  input  logic                           iq_valid,
  input  logic signed [INPUT_WIDTH-1:0]  i_in,
  input  logic signed [INPUT_WIDTH-1:0]  q_in,
  output logic signed [OUTPUT_WIDTH-1:0] demod_out,
  output logic                           demod_valid
);

  localparam int PW = 2 * INPUT_WIDTH;
  localparam int DW = PW + 1;
  localparam int AW = DW + DECIM_LOG2;

  // Handshake: iq_valid is a pure strobe with no ready; every cycle it is high
  // (and RST is low) one sample is consumed. demod_valid is a one-cycle pulse
  // marking the edge at which demod_out took a new value.

  typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;
  state_t state_q, state_d;
  logic   issue;

  logic signed [INPUT_WIDTH-1:0] prev_i, prev_q, cur_i, cur_q;
  logic                          v1, v2, v3;
  logic signed [PW-1:0]          p1, p2;
  logic signed [DW-1:0]          d;
  logic signed [AW-1:0]          acc, acc_sum;
  logic [DECIM_LOG2-1:0]         count;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    if (iq_valid) begin
      case (state_q)
        PRIME:   state_d = RUN;
        RUN:     issue   = 1'b1;
        default: state_d = PRIME;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) state_q <= PRIME;
    else     state_q <= state_d;
  end

  // S1..S3: sample history, products, difference; valid tag shifts every cycle.
  always_ff @(posedge clk_in) begin
    if (RST) begin
      prev_i <= '0;
      prev_q <= '0;
      cur_i  <= '0;
      cur_q  <= '0;
      v1     <= 1'b0;
      p1     <= '0;
      p2     <= '0;
      v2     <= 1'b0;
      d      <= '0;
      v3     <= 1'b0;
    end else begin
      if (iq_valid) begin
        prev_i <= cur_i;
        prev_q <= cur_q;
        cur_i  <= i_in;
        cur_q  <= q_in;
      end
      v1 <= issue;
      p1 <= PW'(prev_i) * PW'(cur_q);
      p2 <= PW'(prev_q) * PW'(cur_i);
      v2 <= v1;
      d  <= DW'(p1) - DW'(p2);
      v3 <= v2;
    end
  end

  always_comb begin
    acc_sum = acc + AW'(d);
  end

  // S4: integrate and dump; the output is the floor of sum / 2^(AW-OUTPUT_WIDTH).
  always_ff @(posedge clk_in) begin
    if (RST) begin
      acc         <= '0;
      count       <= '0;
      demod_out   <= '0;
      demod_valid <= 1'b0;
    end else begin
      demod_valid <= 1'b0;
      if (v3) begin
        if (count == {DECIM_LOG2{1'b1}}) begin
          demod_out   <= acc_sum[AW-1 -: OUTPUT_WIDTH];
          demod_valid <= 1'b1;
          acc         <= '0;
          count       <= '0;
        end else begin
          acc   <= acc_sum;
          count <= count + DECIM_LOG2'(1);
        end
      end
    end
  end

endmodule
